// File: rtl/matmul_pkg.sv
// Shared types and sizing helpers for the matmul host sequencer.
package matmul_pkg;

  // Host sequencer states, in job order
  typedef enum logic [2:0] {
    StLoadA,
    StLoadB,
    StStart,
    StWait,
    StDrain
  } host_state_e;

  // Number of elements in an n x n matrix
  function automatic int unsigned ne(input int unsigned n);
    return n * n;
  endfunction

  // Width of a counter that can hold 0..ne(n)
  function automatic int unsigned elem_cnt_w(input int unsigned n);
    return $clog2(ne(n) + 1);
  endfunction

  localparam int unsigned DefaultMatrixSize = 8;
  localparam int unsigned ElemCntW          = elem_cnt_w(DefaultMatrixSize);

endpackage

// File: rtl/matmul_host_fifo.sv
// Two-entry synchronous FIFO for the C drain path. The head is read straight
// out of storage registers, so there is no combinational path from data_i.
module matmul_host_fifo #(
  parameter int unsigned Width = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             push_i,
  input  logic [Width-1:0] data_i,
  input  logic             pop_i,
  output logic [Width-1:0] data_o,
  output logic             valid_o,
  output logic [1:0]       count_o
);

  logic [Width-1:0] mem_q [2];
  logic             wr_ptr_q;
  logic             rd_ptr_q;
  logic [1:0]       count_q;

  // Storage, pointers and occupancy; push and pop together keep the count
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < 2; i++) mem_q[i] <= '0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      if (push_i) begin
        mem_q[wr_ptr_q] <= data_i;
        wr_ptr_q        <= ~wr_ptr_q;
      end
      if (pop_i) rd_ptr_q <= ~rd_ptr_q;
      count_q <= count_q + {1'b0, push_i} - {1'b0, pop_i};
    end
  end

  assign data_o  = mem_q[rd_ptr_q];
  assign valid_o = (count_q != 2'd0);
  assign count_o = count_q;

endmodule

// File: rtl/matmul_host.sv
// Host sequencer for the matmul core: loads A then B from a valid/ready
// stream, pulses start, waits for a fresh done, then streams C out.
// Optional feature macro: MATMUL_HOST_PERF_EN (compute-phase cycle counter).
module matmul_host
  import matmul_pkg::*;
#(
  parameter int unsigned DATA_WIDTH  = 32,
  parameter int unsigned ADDR_WIDTH  = 10,
  parameter int unsigned MATRIX_SIZE = 8
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] in_din,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic [DATA_WIDTH-1:0] out_dout,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] a_wr_din,
  output logic [ADDR_WIDTH-1:0] a_wr_addr,
  output logic                  a_wr_en,
  output logic [DATA_WIDTH-1:0] b_wr_din,
  output logic [ADDR_WIDTH-1:0] b_wr_addr,
  output logic                  b_wr_en,
  output logic                  start,
  input  logic                  done,
  output logic [ADDR_WIDTH-1:0] c_rd_addr,
  input  logic [DATA_WIDTH-1:0] c_rd_dout,
  output logic                  busy,
  output logic [31:0]           cycle_count
);

  localparam int unsigned     NE      = ne(MATRIX_SIZE);
  localparam int unsigned     CntW    = elem_cnt_w(MATRIX_SIZE);
  localparam logic [CntW-1:0] LastIdx = CntW'(NE - 1);
  localparam logic [CntW-1:0] AllIdx  = CntW'(NE);

  host_state_e           state_q, state_d;
  logic [CntW-1:0]       cnt_q, cnt_d;        // load element index, or drain output index
  logic [CntW-1:0]       rd_cnt_q, rd_cnt_d;  // C reads issued this drain
  logic [ADDR_WIDTH-1:0] rd_addr_q, rd_addr_d;
  logic                  arm_q, arm_d;
  logic                  pend_q, pend_d;      // read whose data lands in the FIFO this cycle
  logic                  busy_q, busy_d;
  logic                  start_q;
  logic                  a_wr_en_q, b_wr_en_q;
  logic [ADDR_WIDTH-1:0] a_wr_addr_q, b_wr_addr_q;
  logic [DATA_WIDTH-1:0] a_wr_din_q, b_wr_din_q;

  logic                  in_hs;
  logic                  fifo_pop;
  logic [1:0]            fifo_count;
  logic [2:0]            slots;
  logic                  issue;

  matmul_host_fifo #(
    .Width (DATA_WIDTH)
  ) u_fifo (
    .clock   (clock),
    .reset   (reset),
    .push_i  (pend_q),
    .data_i  (c_rd_dout),
    .pop_i   (fifo_pop),
    .data_o  (out_dout),
    .valid_o (out_valid),
    .count_o (fifo_count)
  );

  assign in_ready = (state_q == StLoadA) || (state_q == StLoadB);
  assign in_hs    = in_valid & in_ready;
  assign fifo_pop = out_valid & out_ready;
  // A word leaving this cycle frees its slot for a read issued now
  assign slots    = {1'b0, fifo_count} - {2'b0, fifo_pop} + {2'b0, pend_q};

  // Next-state, load/drain counters and read issue
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    rd_cnt_d  = rd_cnt_q;
    rd_addr_d = rd_addr_q;
    arm_d     = arm_q;
    pend_d    = 1'b0;
    issue     = 1'b0;
    unique case (state_q)
      StLoadA, StLoadB: begin
        if (in_hs) begin
          if (cnt_q == LastIdx) begin
            cnt_d   = '0;
            state_d = (state_q == StLoadA) ? StLoadB : StStart;
          end else begin
            cnt_d = cnt_q + CntW'(1);
          end
        end
      end
      StStart: begin
        arm_d   = 1'b0;
        state_d = StWait;
      end
      StWait: begin
        // Only a done seen after a low level belongs to this job
        if (!done) arm_d = 1'b1;
        if (arm_q && done) begin
          state_d   = StDrain;
          rd_cnt_d  = '0;
          rd_addr_d = '0;
        end
      end
      StDrain: begin
        issue = (rd_cnt_q != AllIdx) && (slots < 3'd2);
        if (issue) begin
          rd_cnt_d  = rd_cnt_q + CntW'(1);
          rd_addr_d = rd_addr_q + ADDR_WIDTH'(1);
          pend_d    = 1'b1;
        end
        if (fifo_pop) begin
          if (cnt_q == LastIdx) begin
            cnt_d     = '0;
            rd_cnt_d  = '0;
            rd_addr_d = '0;
            state_d   = StLoadA;
          end else begin
            cnt_d = cnt_q + CntW'(1);
          end
        end
      end
      default: state_d = StLoadA;
    endcase
    busy_d = !((state_d == StLoadA) && (cnt_d == '0));
  end

  // FSM state, counters, and registered start/busy
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q   <= StLoadA;
      cnt_q     <= '0;
      rd_cnt_q  <= '0;
      rd_addr_q <= '0;
      arm_q     <= 1'b0;
      pend_q    <= 1'b0;
      busy_q    <= 1'b0;
      start_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      rd_cnt_q  <= rd_cnt_d;
      rd_addr_q <= rd_addr_d;
      arm_q     <= arm_d;
      pend_q    <= pend_d;
      busy_q    <= busy_d;
      start_q   <= (state_d == StStart);
    end
  end

  // A/B write ports, one cycle behind the input handshake
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      a_wr_en_q   <= 1'b0;
      b_wr_en_q   <= 1'b0;
      a_wr_addr_q <= '0;
      b_wr_addr_q <= '0;
      a_wr_din_q  <= '0;
      b_wr_din_q  <= '0;
    end else begin
      a_wr_en_q <= in_hs && (state_q == StLoadA);
      b_wr_en_q <= in_hs && (state_q == StLoadB);
      if (in_hs && (state_q == StLoadA)) begin
        a_wr_addr_q <= ADDR_WIDTH'(cnt_q);
        a_wr_din_q  <= in_din;
      end
      if (in_hs && (state_q == StLoadB)) begin
        b_wr_addr_q <= ADDR_WIDTH'(cnt_q);
        b_wr_din_q  <= in_din;
      end
    end
  end

`ifdef MATMUL_HOST_PERF_EN
  logic [31:0] cyc_q;

  // Compute-phase cycle counter: cleared in start, saturating count in wait
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cyc_q <= '0;
    end else if (state_q == StStart) begin
      cyc_q <= '0;
    end else if ((state_q == StWait) && (cyc_q != 32'hFFFF_FFFF)) begin
      cyc_q <= cyc_q + 32'd1;
    end
  end

  assign cycle_count = cyc_q;
`else
  assign cycle_count = '0;
`endif

  assign a_wr_en   = a_wr_en_q;
  assign a_wr_addr = a_wr_addr_q;
  assign a_wr_din  = a_wr_din_q;
  assign b_wr_en   = b_wr_en_q;
  assign b_wr_addr = b_wr_addr_q;
  assign b_wr_din  = b_wr_din_q;
  assign start     = start_q;
  assign c_rd_addr = rd_addr_q;
  assign busy      = busy_q;

endmodule

// File: doc/matmul_host.md
# matmul_host

Host-side sequencer for the matmul top level: it drives the A/B write ports, triggers the computation, and streams C back out. It accepts a valid/ready word stream, writes the first MATRIX_SIZE² words to A and the next MATRIX_SIZE² to B, pulses `start`, and waits for `done`. It then reads C from address 0 upward and emits it on a valid/ready output stream with full backpressure support. It sits between a testbench or DMA stream and the matmul top level.

## Interface
- DATA_WIDTH, 32, word width of A/B/C and both streams
- ADDR_WIDTH, 10, BRAM address width; must satisfy 2^ADDR_WIDTH ≥ MATRIX_SIZE²
- MATRIX_SIZE, 8, matrix dimension N; NE = N² elements per matrix
- clock  in  1  sole clock, rising edge
- reset  in  1  asynchronous, active-low
- in_din  in  DATA_WIDTH  input stream data (A then B, row-major)
- in_valid  in  1  input word valid
- in_ready  out  1  input word accepted when in_valid & in_ready
- out_dout  out  DATA_WIDTH  C element, row-major
- out_valid  out  1  output word valid
- out_ready  in  1  downstream accepts
- a_wr_din / a_wr_addr / a_wr_en  out  DATA_WIDTH / ADDR_WIDTH / 1  A write port
- b_wr_din / b_wr_addr / b_wr_en  out  DATA_WIDTH / ADDR_WIDTH / 1  B write port
- start  out  1  single-cycle compute trigger
- done  in  1  compute complete (level)
- c_rd_addr  out  ADDR_WIDTH  C read address; c_rd_dout valid one cycle later
- c_rd_dout  in  DATA_WIDTH  C read data
- busy  out  1  high in every state except S_LOAD_A with element count 0
- cycle_count  out  32  compute-phase cycle count (see Configuration)

## Operation
- FSM states: S_LOAD_A → S_LOAD_B → S_START → S_WAIT → S_DRAIN → S_LOAD_A.
- S_LOAD_A and S_LOAD_B:
  - in_ready = 1.
  - Each handshake registers one write: a_wr_en or b_wr_en = 1 with address = element count and data = in_din.
  - The element count runs 0..NE-1; its width is $clog2(NE+1).
  - After handshake NE-1, the count clears and the FSM advances.
- S_START: start = 1 for exactly one cycle and in_ready = 0. Clears the arm flag. Then go to S_WAIT.
- S_WAIT:
  - Sets the arm flag when done = 0 is sampled.
  - Advances to S_DRAIN when the flag is set and done = 1.
  - A stale `done` left high from the previous job is therefore ignored.
- S_DRAIN:
  - Issues C reads at addresses 0..NE-1 into a 2-entry output FIFO.
  - A read issues only when (fifo_count + reads_in_flight) < 2, so the FIFO never overflows.
  - The FIFO head drives out_dout and out_valid.
  - The FSM leaves S_DRAIN when all NE words have been handshaked out.
- Reset (any state, including mid-wait or mid-drain) returns to S_LOAD_A with counters, FIFO and arm flag cleared. The matmul block is not aborted; its later `done` is ignored by the arm-flag rule.

## Timing
- Reset values:
  - in_ready = 1; out_valid = 0; start = 0; all wr_en = 0.
  - All addresses = 0; busy = 0; cycle_count = 0.
- All outputs are registered except in_ready, which is a combinational decode of state.
- Write latency: input handshake in cycle t → wr_en/addr/din asserted in cycle t+1.
- Read latency: c_rd_addr presented in cycle t → c_rd_dout captured into the FIFO at the end of cycle t+1.
- Without backpressure (out_ready tied 1), the drain emits one word per cycle after 2 cycles of latency; NE+2 cycles total.
- In-to-start: the last B handshake in cycle t → start high in cycle t+1.
- A simultaneous FIFO push and pop leaves the count unchanged.
- out_valid and out_dout stay stable while out_valid & !out_ready.

## Configuration
- MATMUL_HOST_PERF_EN
  - Defined: cycle_count clears in S_START and increments each S_WAIT cycle, saturating at 2^32-1. It holds its value until the next S_START.
  - Undefined: cycle_count is tied to 0 and no counter is synthesized.

## Structure
- Shared package matmul_pkg holds:
  - the state enum typedef;
  - the NE constant function;
  - the element-count width localparam.
- One sub-module, matmul_host_fifo: 2-entry synchronous FIFO with push/pop/count, no combinational in-to-out path.

## Test plan
- Load A = identity and B[i][j] = 8i+j, out_ready = 1 → 64 outputs equal 0..63 in order. busy drops one cycle after the last output.
- Same job, out_ready toggling 1-0-0-1 → output sequence identical; no word dropped or duplicated; out_dout stable while stalled.
- in_valid asserted every third cycle → a_wr_addr/b_wr_addr advance only on handshakes; start pulses exactly once, one cycle after the 128th handshake.
- Hold done = 1 from a previous job into S_WAIT → the FSM stays in S_WAIT until done falls and rises again.
- Assert reset (low) during S_DRAIN at output 20 → all outputs return to reset values in the same cycle. The next job completes correctly.
- With MATMUL_HOST_PERF_EN defined and done rising 100 cycles after start → cycle_count = 100 at S_DRAIN entry. Without the macro it reads 0.
